alu_exec_mem_unit: RTL and testbench

ALU_EXEC_MEM_UNIT -- requirements
Module: alu_exec_mem_unit

---
 rtl/alu_exec_mem_unit_pkg.sv | 48 ++++
 rtl/alu_exec_mem_unit_alu_op_decoder.sv | 21 ++
 rtl/alu_exec_mem_unit.sv | 89 ++++++++
 tb/tb_alu_exec_mem_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_mem_unit_pkg.sv
// Shared encodings for the execute/memory slice.
// ALU op classes, opcodes, ALU operation enum, opcode decode.
package alu_exec_mem_unit_pkg;

  localparam logic [1:0] ALU_OP_R   = 2'b00;
  localparam logic [1:0] ALU_OP_BR  = 2'b01;
  localparam logic [1:0] ALU_OP_MEM = 2'b10;
  localparam logic [1:0] ALU_OP_RSV = 2'b11;

  localparam logic [3:0] OPC_ADD = 4'b0010;
  localparam logic [3:0] OPC_SUB = 4'b0011;
  localparam logic [3:0] OPC_NOT = 4'b0100;
  localparam logic [3:0] OPC_SHL = 4'b0101;
  localparam logic [3:0] OPC_SHR = 4'b0110;
  localparam logic [3:0] OPC_AND = 4'b0111;
  localparam logic [3:0] OPC_OR  = 4'b1000;
  localparam logic [3:0] OPC_SLT = 4'b1001;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_NOT = 3'b010,
    ALU_SHL = 3'b011,
    ALU_SHR = 3'b100,
    ALU_AND = 3'b101,
    ALU_OR  = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  function automatic alu_ctrl_e dec_opcode(
    input logic [3:0] opc
  );
    alu_ctrl_e c;
    case (opc)
      OPC_ADD: c = ALU_ADD;
      OPC_SUB: c = ALU_SUB;
      OPC_NOT: c = ALU_NOT;
      OPC_SHL: c = ALU_SHL;
      OPC_SHR: c = ALU_SHR;
      OPC_AND: c = ALU_AND;
      OPC_OR:  c = ALU_OR;
      OPC_SLT: c = ALU_SLT;
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_exec_mem_unit_alu_op_decoder.sv
// ALU control decode: op class plus opcode to ALU operation.
// Purely combinational.
module alu_op_decoder
  import alu_exec_mem_unit_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [3:0] opcode,
  output alu_ctrl_e  alu_ctrl
);

  // Branch forces subtract, R-type decodes opcode, rest add
  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (1'b1)
      (alu_op == ALU_OP_BR): alu_ctrl = ALU_SUB;
      (alu_op == ALU_OP_R):  alu_ctrl = dec_opcode(opcode);
      default:               alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_mem_unit.sv
// Execute + data memory + writeback select.
// Define ALU_SLT_EN to enable set-less-than (ctrl 111).
module alu_exec_mem_unit
  import alu_exec_mem_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_SIZE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            alu_op,
  input  logic [3:0]            opcode,
  input  logic [DATA_WIDTH-1:0] alu_in_a,
  input  logic [DATA_WIDTH-1:0] alu_in_b,
  input  logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_wr_en,
  input  logic                  mem_rd_en,
  input  logic                  mem_to_reg,
  output logic [2:0]            alu_ctrl,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  zero,
  output logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] wb_data
);

  localparam int AW =
    (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  alu_ctrl_e             ctrl;
  logic [AW-1:0]         addr;
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  alu_op_decoder u_dec (
    .alu_op   (alu_op),
    .opcode   (opcode),
    .alu_ctrl (ctrl)
  );

  assign alu_ctrl = ctrl;

  // ALU: wrapping add/sub, shifts saturate to 0 past width
  always_comb begin
    alu_result = '0;
    case (ctrl)
      ALU_ADD: alu_result = alu_in_a + alu_in_b;
      ALU_SUB: alu_result = alu_in_a - alu_in_b;
      ALU_NOT: alu_result = ~alu_in_a;
      ALU_SHL: alu_result = alu_in_a << alu_in_b;
      ALU_SHR: alu_result = alu_in_a >> alu_in_b;
      ALU_AND: alu_result = alu_in_a & alu_in_b;
      ALU_OR:  alu_result = alu_in_a | alu_in_b;
      ALU_SLT: begin
`ifdef ALU_SLT_EN
        alu_result =
          DATA_WIDTH'(alu_in_a < alu_in_b);
`else
        alu_result = '0;
`endif
      end
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);
  assign addr = alu_result[AW-1:0];

  // Data memory: async clear on reset, sync write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_SIZE; i++)
        mem[i] <= '0;
    end else if (mem_wr_en) begin
      mem[addr] <= mem_wr_data;
    end
  end

  // Combinational read, gated by enable and reset
  always_comb begin
    mem_rd_data = '0;
    if (mem_rd_en && !rst)
      mem_rd_data = mem[addr];
  end

  // Writeback select
  always_comb begin
    wb_data = mem_to_reg ? mem_rd_data : alu_result;
  end

endmodule

// File: tb/tb_alu_exec_mem_unit.sv
// Scoreboard bench for alu_exec_mem_unit.
// Expected values are hand-computed constants.
module tb_alu_exec_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  alu_op;
  logic [3:0]  opcode;
  logic [15:0] a, b, wd;
  logic        we, re, m2r;
  logic [2:0]  ctrl;
  logic [15:0] res, rd, wb;
  logic        z;

  typedef struct {
    string       nm;
    logic [2:0]  ctrl;
    logic [15:0] res;
    logic        z;
    logic [15:0] rd;
    logic [15:0] wb;
  } exp_t;

  exp_t q[$];
  event ev_chk;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef ALU_SLT_EN
  localparam logic [15:0] SLT1 = 16'h0001;
  localparam logic        SLTZ = 1'b0;
`else
  localparam logic [15:0] SLT1 = 16'h0000;
  localparam logic        SLTZ = 1'b1;
`endif

  alu_exec_mem_unit #(
    .DATA_WIDTH (16),
    .MEM_SIZE   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_op      (alu_op),
    .opcode      (opcode),
    .alu_in_a    (a),
    .alu_in_b    (b),
    .mem_wr_data (wd),
    .mem_wr_en   (we),
    .mem_rd_en   (re),
    .mem_to_reg  (m2r),
    .alu_ctrl    (ctrl),
    .alu_result  (res),
    .zero        (z),
    .mem_rd_data (rd),
    .wb_data     (wb)
  );

  always #5 clk = ~clk;

  task automatic cmp(string nm, string f,
                     logic [15:0] act,
                     logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got %h want %h",
               nm, f, act, exp);
    end
  endtask

  // Monitor: pops expectations and checks DUT
  initial begin
    exp_t e;
    forever begin
      @(ev_chk);
      #1;
      while (q.size() != 0) begin
        e = q.pop_front();
        cmp(e.nm, "ctrl", 16'(ctrl), 16'(e.ctrl));
        cmp(e.nm, "res", res, e.res);
        cmp(e.nm, "zero", 16'(z), 16'(e.z));
        cmp(e.nm, "rd", rd, e.rd);
        cmp(e.nm, "wb", wb, e.wb);
      end
    end
  end

  task automatic drv(logic [1:0] op,
                     logic [3:0] opc,
                     logic [15:0] ia, ib,
                     logic [15:0] iwd,
                     logic iwe, ire, im2r);
    alu_op = op; opcode = opc;
    a = ia; b = ib; wd = iwd;
    we = iwe; re = ire; m2r = im2r;
  endtask

  task automatic expect_(string nm,
                         logic [2:0] ec,
                         logic [15:0] er,
                         logic ez,
                         logic [15:0] erd,
                         logic [15:0] ewb);
    exp_t e;
    e.nm = nm; e.ctrl = ec; e.res = er;
    e.z = ez; e.rd = erd; e.wb = ewb;
    q.push_back(e);
    -> ev_chk;
    #2;
  endtask

  // ALU-only vector: no memory access, wb = result
  task automatic alu(string nm,
                     logic [1:0] op,
                     logic [3:0] opc,
                     logic [15:0] ia, ib,
                     logic [2:0] ec,
                     logic [15:0] er,
                     logic ez);
    @(negedge clk);
    drv(op, opc, ia, ib, 16'h0, 0, 0, 0);
    expect_(nm, ec, er, ez, 16'h0, er);
  endtask

  initial begin
    rst = 1'b1;
    drv(2'b00, 4'h0, 16'h0, 16'h0,
        16'h0, 0, 0, 0);
    @(negedge clk);
    expect_("reset", 3'd0, 16'h0, 1, 16'h0, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    alu("add", 2'b00, 4'b0010, 16'd5, 16'd3,
        3'd0, 16'd8, 0);
    alu("br_eq", 2'b01, 4'b0111,
        16'h1234, 16'h1234, 3'd1, 16'h0, 1);
    alu("br_ne", 2'b01, 4'b0000, 16'd1, 16'd2,
        3'd1, 16'hFFFF, 0);
    alu("ldst", 2'b10, 4'b0011, 16'd7, 16'd1,
        3'd0, 16'd8, 0);
    alu("op11", 2'b11, 4'b0011, 16'd7, 16'd1,
        3'd0, 16'd8, 0);
    alu("sub_wrap", 2'b00, 4'b0011, 16'd0, 16'd1,
        3'd1, 16'hFFFF, 0);
    alu("not", 2'b00, 4'b0100, 16'h00FF, 16'h0,
        3'd2, 16'hFF00, 0);
    alu("shl", 2'b00, 4'b0101, 16'd1, 16'd4,
        3'd3, 16'h0010, 0);
    alu("shr15", 2'b00, 4'b0110, 16'h8000,
        16'd15, 3'd4, 16'h0001, 0);
    alu("shr16", 2'b00, 4'b0110, 16'h8000,
        16'd16, 3'd4, 16'h0000, 1);
    alu("shl256", 2'b00, 4'b0101, 16'hFFFF,
        16'h0100, 3'd3, 16'h0000, 1);
    alu("and", 2'b00, 4'b0111, 16'hF0F0,
        16'h0FF0, 3'd5, 16'h00F0, 0);
    alu("or", 2'b00, 4'b1000, 16'hF000,
        16'h000F, 3'd6, 16'hF00F, 0);
    alu("slt_lt", 2'b00, 4'b1001, 16'd2, 16'd3,
        3'd7, SLT1, SLTZ);
    alu("slt_ge", 2'b00, 4'b1001, 16'd3, 16'd2,
        3'd7, 16'h0, 1);
    alu("slt_uns", 2'b00, 4'b1001, 16'd1,
        16'hFFFF, 3'd7, SLT1, SLTZ);
    alu("opc_bad", 2'b00, 4'b1111, 16'hFFFF,
        16'd1, 3'd0, 16'h0, 1);
    alu("opc_0", 2'b00, 4'b0000, 16'd9, 16'd1,
        3'd0, 16'd10, 0);

    // Store BEEF at 3, load through wrapped addr 11
    @(negedge clk);
    drv(2'b10, 4'h0, 16'd3, 16'd0,
        16'hBEEF, 1, 0, 0);
    expect_("st3", 3'd0, 16'd3, 0, 16'h0, 16'd3);
    @(negedge clk);
    drv(2'b10, 4'h0, 16'd11, 16'd0,
        16'h0, 0, 1, 1);
    expect_("ld11", 3'd0, 16'd11, 0,
            16'hBEEF, 16'hBEEF);
    @(negedge clk);
    drv(2'b10, 4'h0, 16'd11, 16'd0,
        16'h0, 0, 0, 1);
    expect_("ld_off", 3'd0, 16'd11, 0,
            16'h0, 16'h0);
    @(negedge clk);
    drv(2'b10, 4'h0, 16'd3, 16'd0,
        16'h0, 0, 1, 0);
    expect_("ld_alu", 3'd0, 16'd3, 0,
            16'hBEEF, 16'd3);

    // Write AAAA at 2, then reset mid-cycle
    @(negedge clk);
    drv(2'b10, 4'h0, 16'd2, 16'd0,
        16'hAAAA, 1, 0, 0);
    @(negedge clk);
    drv(2'b10, 4'h0, 16'd2, 16'd0,
        16'h0, 0, 1, 1);
    expect_("rd2", 3'd0, 16'd2, 0,
            16'hAAAA, 16'hAAAA);
    rst = 1'b1;
    expect_("rst_now", 3'd0, 16'd2, 0,
            16'h0, 16'h0);
    @(negedge clk);
    drv(2'b10, 4'h0, 16'd2, 16'd0,
        16'h5555, 1, 1, 1);
    @(negedge clk);
    expect_("rst_wr", 3'd0, 16'd2, 0,
            16'h0, 16'h0);
    rst = 1'b0;
    drv(2'b10, 4'h0, 16'd2, 16'd0,
        16'h0, 0, 1, 1);
    expect_("post2", 3'd0, 16'd2, 0,
            16'h0, 16'h0);
    @(negedge clk);
    drv(2'b10, 4'h0, 16'd3, 16'd0,
        16'h0, 0, 1, 1);
    expect_("post3", 3'd0, 16'd3, 0,
            16'h0, 16'h0);

    // Same-cycle read/write at 5, no bypass
    @(negedge clk);
    drv(2'b10, 4'h0, 16'd5, 16'd0,
        16'h0001, 1, 0, 0);
    @(negedge clk);
    drv(2'b10, 4'h0, 16'd5, 16'd0,
        16'h0002, 1, 1, 1);
    expect_("rw_old", 3'd0, 16'd5, 0,
            16'h0001, 16'h0001);
    @(posedge clk);
    #1;
    expect_("rw_new", 3'd0, 16'd5, 0,
            16'h0002, 16'h0002);
    @(negedge clk);
    we = 1'b0;

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain left %0d want 0",
               q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
